filter_requant: RTL

//  Back end of the filter chain. Takes the wide signed result stream from the filter
//  and decimates it by DECIM. Each kept sample is rounded, right-shifted by SHIFT and

---
 rtl/filter_pkg.sv | 21 ++
 rtl/requant_fifo.sv | 63 ++++++
 rtl/filter_requant.sv | 116 +++++++++++
 3 files changed

// File: rtl/filter_pkg.sv
// Shared definitions for the filter back end: default widths, saturation
// limits and the {sat, data} FIFO word layout.
package filter_pkg;

  localparam int IN_W_DEF  = 32;
  localparam int OUT_W_DEF = 8;

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

  // FIFO word is {sat, data[w-1:0]}
  function automatic int word_w(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/requant_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word that
// holds its last value once the FIFO drains.
module requant_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop_ready,
  output logic         valid,
  output logic [W-1:0] rdata,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  head_q, head_d;
  logic          full, pop, wr_en;

  always_comb begin
    full     = (count_q == (AW+1)'(DEPTH));
    pop      = (count_q != '0) && pop_ready;
    wr_en    = push && (!full || pop);
    drop     = push && full && !pop;
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    // The head register mirrors mem[rd_ptr]; the incoming word bypasses
    // memory when it becomes the head on this edge.
    head_d = head_q;
    if (wr_en && ((count_q == '0) || (pop && count_q == (AW+1)'(1))))
      head_d = wdata;
    else if (pop && count_q > (AW+1)'(1))
      head_d = mem_q[rd_ptr_q + AW'(1)];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign valid = (count_q != '0);
  assign rdata = head_q;

endmodule

// File: rtl/filter_requant.sv
// Decimate, round, shift and saturate the filter result, then queue it for an
// OUT_W-bit valid/ready consumer. Optional REQUANT_STATS_EN adds sat/drop counters.
module filter_requant
  import filter_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = 8,
  parameter int DECIM = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             overflow
`ifdef REQUANT_STATS_EN
  ,
  output logic [15:0]      sat_cnt,
  output logic [15:0]      drop_cnt
`endif
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int QW = IN_W + 1;
  localparam int WW = word_w(OUT_W);
  localparam logic signed [QW-1:0] Q_MAX = QW'(sat_max(OUT_W));
  localparam logic signed [QW-1:0] Q_MIN = QW'(sat_min(OUT_W));
  localparam logic [QW-1:0]        ONE   = QW'(1);
  localparam logic signed [QW-1:0] RND   = signed'(ONE << (SHIFT - 1));

  logic [PW-1:0]          phase_q, phase_d;
  logic                   s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic signed [QW-1:0]   s1_val_q, s1_val_d, r;
  logic [WW-1:0]          s2_word_q, s2_word_d, head;
  logic                   overflow_q, overflow_d, keep, fifo_drop;

  always_comb begin
    keep    = in_valid && (phase_q == '0);
    phase_d = phase_q;
    if (in_valid) phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
    // One extra bit keeps the rounding add from wrapping near +max.
    r          = signed'({in_data[IN_W-1], in_data}) + RND;
    s1_val_d   = r >>> SHIFT;
    s1_valid_d = keep;
    s2_valid_d = s1_valid_q;
    if (s1_val_q > Q_MAX)      s2_word_d = {1'b1, Q_MAX[OUT_W-1:0]};
    else if (s1_val_q < Q_MIN) s2_word_d = {1'b1, Q_MIN[OUT_W-1:0]};
    else                       s2_word_d = {1'b0, s1_val_q[OUT_W-1:0]};
    overflow_d = overflow_q | fifo_drop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_val_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_word_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      s1_valid_q <= s1_valid_d;
      s1_val_q   <= s1_val_d;
      s2_valid_q <= s2_valid_d;
      s2_word_q  <= s2_word_d;
      overflow_q <= overflow_d;
    end
  end

  requant_fifo #(.W(WW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (s2_valid_q),
    .wdata     (s2_word_q),
    .pop_ready (out_ready),
    .valid     (out_valid),
    .rdata     (head),
    .drop      (fifo_drop)
  );

  assign out_sat  = head[WW-1];
  assign out_data = head[OUT_W-1:0];
  assign overflow = overflow_q;

`ifdef REQUANT_STATS_EN
  logic [15:0] sat_cnt_q, sat_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    sat_cnt_d  = sat_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (s2_valid_q && !fifo_drop && s2_word_q[WW-1] && sat_cnt_q != 16'hFFFF)
      sat_cnt_d = sat_cnt_q + 16'd1;
    if (fifo_drop && drop_cnt_q != 16'hFFFF)
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      sat_cnt_q  <= sat_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign sat_cnt  = sat_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule
